silife_matrix_8x8: RTL and testbench
====================================

// Module: silife_matrix_8x8
// PURPOSE
//  8x8 tile of Conway's Game of Life cells, one clock, one generation per enabled cycle.
//  Tiles into larger boards: edge/corner neighbour states enter via i_* ports from adjacent tiles.
//  Host loads patterns row-by-row (row_select/set_cells) and reads one row at a time on cells.
// PARAMETERS
//  none (grid fixed at 8 rows x 8 columns)
// PORTS
//  clk         in   1  rising-edge clock
//  reset       in   1  synchronous, active-high; clears every cell
//  enable      in   1  1 = advance one generation this cycle; 0 = hold
//  row_select  in   3  row index 0..7 for set_cells and cells
//  set_cells   in   8  bit c=1 forces cell (row_select,c) alive at next edge
//  cells       out  8  current state of row row_select, bit c = column c
//  i_nw        in   1  cell diagonally NW of (0,0)
//  i_ne        in   1  cell diagonally NE of (0,7)
//  i_sw        in   1  cell diagonally SW of (7,0)
//  i_se        in   1  cell diagonally SE of (7,7)
//  i_n         in   8  i_n[c] = cell above (0,c)
//  i_s         in   8  i_s[c] = cell below (7,c)
//  i_w         in   8  i_w[r] = cell left of (r,0)
//  i_e         in   8  i_e[r] = cell right of (r,7)
// BEHAVIOUR
//  - State: reg [63:0] cell_values; cell (r,c) = cell_values[r*8+c]; row 0 = north, column 0 = west.
//    Signal name cell_values is fixed so benches probe it hierarchically.
//  - Per-cell priority at each rising edge:
//    1. reset: 0.
//    2. set_cells[c] && row_select==r: 1.
//    3. enable: next-generation value.
//    4. otherwise: hold.
//  - set_cells bits = 0 never clear a cell; set only affects the selected row.
//    Unselected rows of the same cycle still evolve if enable=1.
//  - Next generation (B3/S23):
//    count the 8 neighbours (4-bit sum, 0..8);
//    alive & count in {2,3} -> 1; dead & count==3 -> 1; else 0.
//  - Neighbours outside the tile come from i_n/i_s/i_e/i_w/corners; no wrap-around inside the tile.
//    All-zero edge inputs = dead border.
//  - All cells update simultaneously from pre-edge state (no partial-update ordering).
//  - cells = cell_values[row_select*8 +: 8], purely combinational, reflects current registered state.
//  - Reset value: cell_values = 0, hence cells = 0 for any row_select.
//    Reset mid-run wins over set and enable.
//  - Latency: set visible on cells 1 cycle after the edge; each generation is 1 cycle.
// STRUCTURE
//  - Shared package silife_pkg: localparam ROWS=8, COLS=8, NEIGHBOURS=8.
//  - Sub-module silife_cell: clk, reset, enable, revive, [7:0] neighbours -> state;
//    holds the priority logic and the B3/S23 rule.
//  - Top generates 64 silife_cell instances and maps edge/corner inputs into border neighbour vectors.
// TESTING
//  - Reset: hold reset 1 cycle, sweep row_select 0..7 -> cells==8'h00 on every row.
//  - Blinker: release reset, row 4 set_cells=8'b0111_0000 for 1 cycle (enable=1), then set_cells=0.
//    -> row 4 = 0x70, then column 5 rows 3-5 alive, then row 4 = 0x70 again; period 2.
//  - Still life: block at (2,2),(2,3),(3,2),(3,3) -> unchanged for 5 generations.
//  - Hold: load blinker, enable=0 for 4 cycles -> no change; enable=1 -> resumes oscillating.
//  - Edge inputs: i_n=8'b0000_1110 held, tile empty -> after 1 generation cell (0,2) alive only
//    (3 neighbours); cells (0,1),(0,3) stay dead (2 neighbours).
//    Repeat via i_w and i_se on the corner cell.
//  - Set priority: set_cells on a cell that the rule would kill -> cell is 1 after the edge;
//    reset asserted with set -> 0.

Source files
------------

// File: rtl/silife_pkg.sv
// silife_pkg: shared grid constants and neighbour-count helper for the Life tile
package silife_pkg;

    localparam int ROWS       = 8;
    localparam int COLS       = 8;
    localparam int NEIGHBOURS = 8;

    // Population count of the eight neighbour bits (0..8).
    function automatic logic [3:0] count_alive(input logic [NEIGHBOURS-1:0] n);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NEIGHBOURS; i++) cnt = cnt + {3'b000, n[i]};
        return cnt;
    endfunction

endpackage

// File: rtl/silife_cell.sv
// silife_cell: one Life cell with reset > revive > evolve > hold priority
//   clk, reset   clock and synchronous active-high clear
//   enable       advance one generation at this edge
//   revive       force the cell alive at this edge
//   neighbours   states of the eight surrounding cells
//   state        registered cell state
module silife_cell
    import silife_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  revive,
    input  logic [NEIGHBOURS-1:0] neighbours,
    output logic                  state
);

    logic       state_q;
    logic       state_d;
    logic [3:0] cnt;
    logic       next_gen;

    assign cnt      = count_alive(neighbours);
    // B3/S23: birth on exactly 3, survival on 2 or 3.
    assign next_gen = (cnt == 4'd3) | (state_q & (cnt == 4'd2));

    always_comb begin
        state_d = reset  ? 1'b0 :
                  revive ? 1'b1 :
                  enable ? next_gen : state_q;
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/silife_matrix_8x8.sv
// silife_matrix_8x8: tileable 8x8 Game of Life block, one generation per enabled cycle
//   clk, reset          clock and synchronous active-high clear of all cells
//   enable              advance one generation
//   row_select          row addressed by set_cells and cells
//   set_cells           per-column force-alive for the selected row
//   cells               current state of the selected row
//   i_nw/i_ne/i_sw/i_se diagonal corner neighbours from adjacent tiles
//   i_n/i_s/i_w/i_e     edge neighbours from adjacent tiles
module silife_matrix_8x8
    import silife_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] row_select,
    input  logic [7:0] set_cells,
    output logic [7:0] cells,
    input  logic       i_nw,
    input  logic       i_ne,
    input  logic       i_sw,
    input  logic       i_se,
    input  logic [7:0] i_n,
    input  logic [7:0] i_s,
    input  logic [7:0] i_w,
    input  logic [7:0] i_e
);

    logic [ROWS*COLS-1:0] cell_values;

    // Padded 10x10 view: ext[row][col], tile cell (r,c) sits at ext[r+1][c+1],
    // the ring around it carries the neighbouring tiles' edge states.
    logic [COLS+1:0] ext [ROWS+2];

    assign ext[0]      = {i_ne, i_n, i_nw};
    assign ext[ROWS+1] = {i_se, i_s, i_sw};

    genvar r, c;
    generate
        for (r = 0; r < ROWS; r++) begin : g_row
            assign ext[r+1] = {i_e[r], cell_values[r*COLS +: COLS], i_w[r]};
            for (c = 0; c < COLS; c++) begin : g_col
                silife_cell u_cell (
                    .clk        (clk),
                    .reset      (reset),
                    .enable     (enable),
                    .revive     (set_cells[c] && (row_select == 3'(r))),
                    .neighbours ({ext[r][c+2:c], ext[r+1][c+2], ext[r+1][c], ext[r+2][c+2:c]}),
                    .state      (cell_values[r*COLS+c])
                );
            end
        end
    endgenerate

    assign cells = cell_values[{row_select, 3'b000} +: 8];

endmodule

// File: tb/tb_silife_matrix_8x8.sv
// tb_silife_matrix_8x8: directed self-checking bench for the 8x8 Life tile
module tb_silife_matrix_8x8;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] row_select;
    logic [7:0] set_cells;
    logic [7:0] cells;
    logic       i_nw, i_ne, i_sw, i_se;
    logic [7:0] i_n, i_s, i_w, i_e;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] BLINK_H = 64'h0000_0070_0000_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_2020_2000_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0C0C_0000;

    silife_matrix_8x8 dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .row_select (row_select),
        .set_cells  (set_cells),
        .cells      (cells),
        .i_nw       (i_nw),
        .i_ne       (i_ne),
        .i_sw       (i_sw),
        .i_se       (i_se),
        .i_n        (i_n),
        .i_s        (i_s),
        .i_w        (i_w),
        .i_e        (i_e)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; enable = 0; row_select = 0; set_cells = 0;
        i_nw = 0; i_ne = 0; i_sw = 0; i_se = 0;
        i_n = 0; i_s = 0; i_w = 0; i_e = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int r = 0; r < 8; r++) begin
            row_select = 3'(r);
            #1;
            n_cmp++;
            if (cells !== 8'h00) begin
                n_err++;
                $display("FAIL reset_row%0d: got %h expected 00", r, cells);
            end
        end
    endtask

    task automatic test_blinker();
        do_reset();
        enable = 1; row_select = 3'd4; set_cells = 8'b0111_0000;
        tick();
        set_cells = 0;
        n_cmp++;
        if (cells !== 8'h70) begin
            n_err++;
            $display("FAIL blinker_row4: got %h expected 70", cells);
        end
        for (int g = 0; g < 4; g++) begin
            tick();
            n_cmp++;
            if (dut.cell_values !== ((g % 2 == 0) ? BLINK_V : BLINK_H)) begin
                n_err++;
                $display("FAIL blinker_gen%0d: got %h expected %h", g, dut.cell_values,
                         (g % 2 == 0) ? BLINK_V : BLINK_H);
            end
        end
        row_select = 3'd3;
        tick();
        n_cmp++;
        if (cells !== 8'h20) begin
            n_err++;
            $display("FAIL blinker_row3: got %h expected 20", cells);
        end
    endtask

    task automatic test_still_life();
        do_reset();
        row_select = 3'd2; set_cells = 8'h0C;
        tick();
        row_select = 3'd3;
        tick();
        set_cells = 0; enable = 1;
        for (int g = 0; g < 5; g++) begin
            tick();
            n_cmp++;
            if (dut.cell_values !== BLOCK) begin
                n_err++;
                $display("FAIL block_gen%0d: got %h expected %h", g, dut.cell_values, BLOCK);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        row_select = 3'd4; set_cells = 8'h70;
        tick();
        set_cells = 0;
        for (int h = 0; h < 4; h++) begin
            tick();
            n_cmp++;
            if (dut.cell_values !== BLINK_H) begin
                n_err++;
                $display("FAIL hold_cyc%0d: got %h expected %h", h, dut.cell_values, BLINK_H);
            end
        end
        enable = 1;
        tick();
        n_cmp++;
        if (dut.cell_values !== BLINK_V) begin
            n_err++;
            $display("FAIL hold_resume1: got %h expected %h", dut.cell_values, BLINK_V);
        end
        tick();
        n_cmp++;
        if (dut.cell_values !== BLINK_H) begin
            n_err++;
            $display("FAIL hold_resume2: got %h expected %h", dut.cell_values, BLINK_H);
        end
    endtask

    task automatic test_edges();
        do_reset();
        i_n = 8'b0000_1110; enable = 1;
        tick();
        n_cmp++;
        if (dut.cell_values !== 64'h4) begin
            n_err++;
            $display("FAIL edge_north: got %h expected %h", dut.cell_values, 64'h4);
        end
        do_reset();
        i_w = 8'b0000_1110; enable = 1;
        tick();
        n_cmp++;
        if (dut.cell_values !== 64'h1_0000) begin
            n_err++;
            $display("FAIL edge_west: got %h expected %h", dut.cell_values, 64'h1_0000);
        end
        do_reset();
        i_se = 1; i_s = 8'h80; i_e = 8'h80; enable = 1;
        tick();
        n_cmp++;
        if (dut.cell_values !== 64'h8000_0000_0000_0000) begin
            n_err++;
            $display("FAIL edge_se_corner: got %h expected %h", dut.cell_values,
                     64'h8000_0000_0000_0000);
        end
        do_reset();
        i_nw = 1; i_ne = 1; i_sw = 1; enable = 1;
        tick();
        n_cmp++;
        if (dut.cell_values !== 64'h0) begin
            n_err++;
            $display("FAIL edge_lone_corners: got %h expected 0", dut.cell_values);
        end
    endtask

    task automatic test_set_priority();
        do_reset();
        enable = 1; row_select = 3'd5; set_cells = 8'h20;
        tick();
        tick();
        n_cmp++;
        if (dut.cell_values !== 64'h0000_2000_0000_0000) begin
            n_err++;
            $display("FAIL set_over_rule: got %h expected %h", dut.cell_values,
                     64'h0000_2000_0000_0000);
        end
        reset = 1;
        tick();
        reset = 0; set_cells = 0;
        n_cmp++;
        if (dut.cell_values !== 64'h0) begin
            n_err++;
            $display("FAIL reset_over_set: got %h expected 0", dut.cell_values);
        end
        enable = 0; row_select = 3'd4; set_cells = 8'h70;
        tick();
        enable = 1; set_cells = 0;
        tick();
        enable = 0; set_cells = 8'h01;
        tick();
        set_cells = 0;
        n_cmp++;
        if (dut.cell_values !== 64'h0000_2021_2000_0000) begin
            n_err++;
            $display("FAIL set_no_clear: got %h expected %h", dut.cell_values,
                     64'h0000_2021_2000_0000);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_blinker();
        test_still_life();
        test_hold();
        test_edges();
        test_set_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
